// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters (m0 core LSU, m1 loader),
// the arbiter and the memory dmem port. WORD_LEN sets data/address width.
interface dmem_arbiter_if #(
  parameter int WORD_LEN = 32
);
  logic                m0_req;
  logic                m0_we;
  logic [WORD_LEN-1:0] m0_addr;
  logic [WORD_LEN-1:0] m0_wdata;
  logic                m0_gnt;
  logic                m0_rvalid;
  logic [WORD_LEN-1:0] m0_rdata;

  logic                m1_req;
  logic                m1_we;
  logic [WORD_LEN-1:0] m1_addr;
  logic [WORD_LEN-1:0] m1_wdata;
  logic [4:0]          m1_len;
  logic                m1_gnt;
  logic                m1_rvalid;
  logic [WORD_LEN-1:0] m1_rdata;

  logic [WORD_LEN-1:0] mem_addr;
  logic                mem_wen;
  logic [WORD_LEN-1:0] mem_wdata;
  logic [WORD_LEN-1:0] mem_rdata;

  logic                busy;

  // Arbiter view.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_len,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_addr, mem_wen, mem_wdata,
    input  mem_rdata,
    output busy
  );

  // Environment view: requesters plus the memory returning read data.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_len,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_addr, mem_wen, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the unified memory data port with locked m1 bursts.
// Define DMEM_ARB_RR_EN for round-robin IDLE arbitration (default: fixed m0 > m1).
module dmem_arbiter #(
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic          busy_reg;
  logic          m0_rvalid_reg;
  logic          m1_rvalid_reg;

  logic          m0_gnt;
  logic          m1_gnt;
  logic          m0_pri;
  logic [CW-1:0] eff_len;

  // A zero length still moves one word; oversize requests are clamped.
  always_comb begin
    if (bus.m1_len == 5'd0)
      eff_len = CW'(1);
    else if (int'(bus.m1_len) > MAX_BURST)
      eff_len = CW'(MAX_BURST);
    else
      eff_len = CW'(bus.m1_len);
  end

`ifdef DMEM_ARB_RR_EN
  logic last_gnt_reg;  // 1 = m1 was granted most recently

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_gnt_reg <= 1'b1;
    else if (m0_gnt)
      last_gnt_reg <= 1'b0;
    else if (m1_gnt)
      last_gnt_reg <= 1'b1;
  end

  assign m0_pri = last_gnt_reg;
`else
  assign m0_pri = 1'b1;
`endif

  // Grants are gated by rst_n so they drop in the same cycle reset asserts.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst_n) begin
      case (state_reg)
        IDLE: begin
          m0_gnt = bus.m0_req && (!bus.m1_req || m0_pri);
          m1_gnt = bus.m1_req && !(bus.m0_req && m0_pri);
        end
        BURST: begin
          m1_gnt = bus.m1_req;
        end
        default: begin
          m0_gnt = 1'b0;
          m1_gnt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      busy_reg      <= 1'b0;
      m0_rvalid_reg <= 1'b0;
      m1_rvalid_reg <= 1'b0;
    end else begin
      // Memory read latency is one cycle, so the tag is simply the delayed grant.
      m0_rvalid_reg <= m0_gnt && !bus.m0_we;
      m1_rvalid_reg <= m1_gnt && !bus.m1_we;
      case (state_reg)
        IDLE: begin
          if (m1_gnt && (eff_len > CW'(1))) begin
            state_reg <= BURST;
            cnt_reg   <= eff_len - CW'(1);
            busy_reg  <= 1'b1;
          end
        end
        BURST: begin
          if (!bus.m1_req || (cnt_reg == CW'(1))) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr  = m1_gnt ? bus.m1_addr  : bus.m0_addr;
  assign bus.mem_wdata = m1_gnt ? bus.m1_wdata : bus.m0_wdata;
  assign bus.mem_wen   = (m0_gnt && bus.m0_we) || (m1_gnt && bus.m1_we);

  assign bus.m0_gnt    = m0_gnt;
  assign bus.m1_gnt    = m1_gnt;
  assign bus.m0_rvalid = m0_rvalid_reg;
  assign bus.m1_rvalid = m1_rvalid_reg;
  assign bus.m0_rdata  = bus.mem_rdata;
  assign bus.m1_rdata  = bus.mem_rdata;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: table of single-cycle accesses plus
// hand-written burst, abort, priority and reset sequences.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.WORD_LEN(32)) bus ();

  dmem_arbiter #(.MAX_BURST(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory model with a registered read port.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.mem_wen) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[9:2]];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic [4:0] len);
    @(negedge clk);
    bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
    bus.m1_req = r1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
    bus.m1_len = len;
    #2;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [4:0]  m1_len;
    logic        e_gnt0;
    logic        e_gnt1;
    logic        e_wen;
    logic [31:0] e_addr;
    logic        e_rv0;
    logic        e_rv1;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt [8];
  logic exp_g0 [3];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
    mem[4] = 32'hDEAD_BEEF;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h10; bus.m0_wdata = '0;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h30; bus.m1_wdata = '0;
    bus.m1_len = 5'd4;

    //            m0 req/we addr   wdata          m1 req/we addr   wdata          len    g0    g1    wen   addr    rv0   rv1   rdata
    vt[0] = '{1'b1, 1'b0, 32'h10, 32'h0,         1'b0, 1'b0, 32'h0,  32'h0,         5'd1, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vt[1] = '{1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 1'b0, 32'h0,  32'h0,         5'd1, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0};
    vt[2] = '{1'b1, 1'b0, 32'h20, 32'h0,         1'b0, 1'b0, 32'h0,  32'h0,         5'd1, 1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 1'b0, 32'h1234_5678};
    vt[3] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h30, 32'h0,         5'd1, 1'b0, 1'b1, 1'b0, 32'h30, 1'b0, 1'b1, 32'hA000_000C};
    vt[4] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b1, 32'h40, 32'hCAFE_0001, 5'd0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0};
    vt[5] = '{1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h40, 32'h0,         5'd1, 1'b0, 1'b1, 1'b0, 32'h40, 1'b0, 1'b1, 32'hCAFE_0001};
    vt[6] = '{1'b0, 1'b1, 32'h50, 32'h5555_5555, 1'b0, 1'b1, 32'h60, 32'h6666_6666, 5'd1, 1'b0, 1'b0, 1'b0, 32'h50, 1'b0, 1'b0, 32'h0};
    vt[7] = '{1'b1, 1'b0, 32'h10, 32'h0,         1'b1, 1'b0, 32'h30, 32'h0,         5'd1, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 32'hDEAD_BEEF};

    // Reset state: requests present but nothing granted.
    #2;
    chk("rst_m0_gnt", {31'b0, bus.m0_gnt}, 32'd0);
    chk("rst_m1_gnt", {31'b0, bus.m1_gnt}, 32'd0);
    after_edge();
    chk("rst_m0_rvalid", {31'b0, bus.m0_rvalid}, 32'd0);
    chk("rst_m1_rvalid", {31'b0, bus.m1_rvalid}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_wen", {31'b0, bus.mem_wen}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd1);
    rst_n = 1'b1;
    after_edge();

    // Table of single accesses applied back to back.
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].m0_req, vt[i].m0_we, vt[i].m0_addr, vt[i].m0_wdata,
            vt[i].m1_req, vt[i].m1_we, vt[i].m1_addr, vt[i].m1_wdata, vt[i].m1_len);
      $display("vec %0d: gnt0=%b gnt1=%b wen=%b addr=%h", i, bus.m0_gnt, bus.m1_gnt, bus.mem_wen, bus.mem_addr);
      chk($sformatf("v%0d_m0_gnt", i), {31'b0, bus.m0_gnt}, {31'b0, vt[i].e_gnt0});
      chk($sformatf("v%0d_m1_gnt", i), {31'b0, bus.m1_gnt}, {31'b0, vt[i].e_gnt1});
      chk($sformatf("v%0d_wen", i), {31'b0, bus.mem_wen}, {31'b0, vt[i].e_wen});
      chk($sformatf("v%0d_addr", i), bus.mem_addr, vt[i].e_addr);
      if (vt[i].e_wen)
        chk($sformatf("v%0d_wdata", i), bus.mem_wdata, vt[i].e_gnt1 ? vt[i].m1_wdata : vt[i].m0_wdata);
      after_edge();
      chk($sformatf("v%0d_m0_rvalid", i), {31'b0, bus.m0_rvalid}, {31'b0, vt[i].e_rv0});
      chk($sformatf("v%0d_m1_rvalid", i), {31'b0, bus.m1_rvalid}, {31'b0, vt[i].e_rv1});
      chk($sformatf("v%0d_busy", i), {31'b0, bus.busy}, 32'd0);
      if (vt[i].e_rv0) chk($sformatf("v%0d_m0_rdata", i), bus.m0_rdata, vt[i].e_rdata);
      if (vt[i].e_rv1) chk($sformatf("v%0d_m1_rdata", i), bus.m1_rdata, vt[i].e_rdata);
    end

    // Both requesting for three cycles, after a lone m1 beat.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, 5'd1);
    chk("pre2_m1_gnt", {31'b0, bus.m1_gnt}, 32'd1);
    after_edge();
`ifdef DMEM_ARB_RR_EN
    exp_g0 = '{1'b1, 1'b0, 1'b1};
`else
    exp_g0 = '{1'b1, 1'b1, 1'b1};
`endif
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, 5'd1);
      $display("both %0d: gnt0=%b gnt1=%b", k, bus.m0_gnt, bus.m1_gnt);
      chk($sformatf("both%0d_m0_gnt", k), {31'b0, bus.m0_gnt}, {31'b0, exp_g0[k]});
      chk($sformatf("both%0d_m1_gnt", k), {31'b0, bus.m1_gnt}, {31'b0, !exp_g0[k]});
      after_edge();
    end

    // Locked write burst of 4 while m0 keeps requesting.
    for (int k = 0; k < 4; k++) begin
      drive(k != 0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h100 + 32'(4 * k), 32'hB000_0000 + 32'(k), 5'd4);
      $display("burst4 beat %0d: gnt0=%b gnt1=%b busy=%b", k, bus.m0_gnt, bus.m1_gnt, bus.busy);
      chk($sformatf("b4_%0d_m1_gnt", k), {31'b0, bus.m1_gnt}, 32'd1);
      chk($sformatf("b4_%0d_m0_gnt", k), {31'b0, bus.m0_gnt}, 32'd0);
      chk($sformatf("b4_%0d_addr", k), bus.mem_addr, 32'h100 + 32'(4 * k));
      after_edge();
      chk($sformatf("b4_%0d_busy", k), {31'b0, bus.busy}, {31'b0, k < 3});
    end
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h110, 32'h0, 5'd1);
    chk("b4_after_m0_gnt", {31'b0, bus.m0_gnt}, 32'd1);
    chk("b4_after_m1_gnt", {31'b0, bus.m1_gnt}, 32'd0);
    after_edge();
    for (int k = 0; k < 4; k++)
      chk($sformatf("b4_mem%0d", k), mem[64 + k], 32'hB000_0000 + 32'(k));

    // Zero length is a single beat.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h180, 32'h7777_0000, 5'd0);
    chk("len0_m1_gnt", {31'b0, bus.m1_gnt}, 32'd1);
    after_edge();
    chk("len0_busy", {31'b0, bus.busy}, 32'd0);

    // Oversize length clamps to 16 beats.
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h200 + 32'(4 * k), 32'hC000_0000 + 32'(k), 5'd31);
      $display("burst31 beat %0d: gnt1=%b busy=%b", k, bus.m1_gnt, bus.busy);
      chk($sformatf("b31_%0d_m1_gnt", k), {31'b0, bus.m1_gnt}, 32'd1);
      after_edge();
      chk($sformatf("b31_%0d_busy", k), {31'b0, bus.busy}, {31'b0, k < 15});
    end
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h240, 32'h0, 5'd1);
    chk("b31_after_m0_gnt", {31'b0, bus.m0_gnt}, 32'd1);
    chk("b31_after_m1_gnt", {31'b0, bus.m1_gnt}, 32'd0);
    after_edge();
    chk("b31_mem_last", mem[143], 32'hC000_000F);

    // Burst of 8 aborted after the third beat.
    for (int k = 0; k < 3; k++) begin
      drive(k != 0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h30 + 32'(4 * k), 32'h0, 5'd8);
      chk($sformatf("ab_%0d_m1_gnt", k), {31'b0, bus.m1_gnt}, 32'd1);
      chk($sformatf("ab_%0d_m0_gnt", k), {31'b0, bus.m0_gnt}, 32'd0);
      after_edge();
      chk($sformatf("ab_%0d_busy", k), {31'b0, bus.busy}, 32'd1);
    end
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h3C, 32'h0, 5'd8);
    $display("abort: gnt0=%b gnt1=%b busy=%b", bus.m0_gnt, bus.m1_gnt, bus.busy);
    chk("ab_drop_m0_gnt", {31'b0, bus.m0_gnt}, 32'd0);
    chk("ab_drop_m1_gnt", {31'b0, bus.m1_gnt}, 32'd0);
    after_edge();
    chk("ab_drop_busy", {31'b0, bus.busy}, 32'd0);
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h3C, 32'h0, 5'd8);
    chk("ab_regain_m0_gnt", {31'b0, bus.m0_gnt}, 32'd1);
    after_edge();
    chk("ab_regain_rdata", bus.m0_rdata, 32'hDEAD_BEEF);

    // Reset mid-burst with an m1 read return pending.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, 5'd4);
    chk("rb_m1_gnt", {31'b0, bus.m1_gnt}, 32'd1);
    after_edge();
    chk("rb_busy_pre", {31'b0, bus.busy}, 32'd1);
    chk("rb_rvalid_pre", {31'b0, bus.m1_rvalid}, 32'd1);
    rst_n = 1'b0;
    #1;
    $display("reset mid-burst: gnt1=%b rvalid1=%b busy=%b", bus.m1_gnt, bus.m1_rvalid, bus.busy);
    chk("rb_m1_gnt_rst", {31'b0, bus.m1_gnt}, 32'd0);
    chk("rb_rvalid_rst", {31'b0, bus.m1_rvalid}, 32'd0);
    chk("rb_busy_rst", {31'b0, bus.busy}, 32'd0);
    after_edge();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd1);
    rst_n = 1'b1;
    #1;
    chk("rb_m0_gnt_post", {31'b0, bus.m0_gnt}, 32'd1);
    after_edge();
    chk("rb_busy_post", {31'b0, bus.busy}, 32'd0);
    chk("rb_m0_rvalid_post", {31'b0, bus.m0_rvalid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
